// File: rtl/tt_um_hoene_frame_sequencer_pkg.sv
// Shared definitions for the LED frame sequencer and protocol-selection logic.
package tt_um_hoene_frame_sequencer_pkg;

  // Encoding is fixed because the protocol-selection logic decodes these values.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCAL   = 2'd1,
    ST_FORWARD = 2'd2,
    ST_HALT    = 2'd3
  } seq_state_t;

  localparam int BIT_CNT_W = 5;

  // The parity bit follows the last data bit, so its slot index equals the data width.
  function automatic logic [BIT_CNT_W-1:0] parity_slot(input int data_bits);
    return BIT_CNT_W'(data_bits);
  endfunction

endpackage

// File: rtl/tt_um_hoene_frame_shift.sv
// Bit position counter, data shift register and running parity for one word.
module tt_um_hoene_frame_shift
  import tt_um_hoene_frame_sequencer_pkg::*;
#(
  parameter int DATA_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 bit_en,
  input  logic                 in_data,
  output logic [BIT_CNT_W-1:0] bit_counter,
  output logic [DATA_BITS-1:0] data,
  output logic                 word_done,
  output logic                 parity_ok
);

  localparam logic [BIT_CNT_W-1:0] SLOT = parity_slot(DATA_BITS);

  logic parity;

  // The incoming parity bit itself closes the word, so the check folds it in directly.
  assign word_done = bit_en && (bit_counter == SLOT);
  assign parity_ok = ~(parity ^ in_data);

  // Shift data bits MSB first; the parity slot wraps the counter and restarts parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_counter <= '0;
      parity      <= 1'b0;
      data        <= '0;
    end else if (clear) begin
      bit_counter <= '0;
      parity      <= 1'b0;
    end else if (bit_en) begin
      if (bit_counter == SLOT) begin
        bit_counter <= '0;
        parity      <= 1'b0;
      end else begin
        data        <= DATA_BITS'({data, in_data});
        bit_counter <= bit_counter + 1'b1;
        parity      <= parity ^ in_data;
      end
    end
  end

endmodule

// File: rtl/tt_um_hoene_frame_sequencer.sv
// Frame sequencer: local word capture, forwarding enable and link supervision.
module tt_um_hoene_frame_sequencer
  import tt_um_hoene_frame_sequencer_pkg::*;
#(
  parameter int DATA_BITS   = 24,
  parameter int LOCAL_WORDS = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_data,
  input  logic                 in_clk,
  input  logic                 in_sync,
  output logic [4:0]           bit_counter,
  output logic [DATA_BITS-1:0] word_data,
  output logic                 word_valid,
  output logic                 fwd_enable,
  output logic                 parity_error,
  output logic                 timeout
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int WORD_W = $clog2(LOCAL_WORDS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(LOCAL_WORDS - 1);
  localparam logic [WORD_W-1:0] WORD_MAX  = WORD_W'(LOCAL_WORDS);

  seq_state_t          state;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [WORD_W-1:0]   word_cnt;
  logic                bit_en;
  logic                word_done;
  logic                parity_ok;
  logic [DATA_BITS-1:0] shift_data;

  // Bits are taken in IDLE too, so the first in_clk of a frame is never lost.
  assign bit_en = in_sync && in_clk && (state != ST_HALT);

  tt_um_hoene_frame_shift #(
    .DATA_BITS(DATA_BITS)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .clear      (!in_sync),
    .bit_en     (bit_en),
    .in_data    (in_data),
    .bit_counter(bit_counter),
    .data       (shift_data),
    .word_done  (word_done),
    .parity_ok  (parity_ok)
  );

  // Frame FSM with word/idle counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idle_cnt     <= '0;
      word_cnt     <= '0;
      word_data    <= '0;
      word_valid   <= 1'b0;
      fwd_enable   <= 1'b0;
      parity_error <= 1'b0;
      timeout      <= 1'b0;
    end else if (!in_sync) begin
      state        <= ST_IDLE;
      idle_cnt     <= '0;
      word_cnt     <= '0;
      word_valid   <= 1'b0;
      fwd_enable   <= 1'b0;
      parity_error <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      case (state)
        ST_IDLE: state <= ST_LOCAL;
        ST_LOCAL, ST_FORWARD: begin
          if (!in_clk) begin
            if (idle_cnt == IDLE_LAST) begin
              idle_cnt   <= idle_cnt + 1'b1;
              timeout    <= 1'b1;
              fwd_enable <= 1'b0;
              state      <= ST_HALT;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
            if (word_done) begin
              if (state == ST_LOCAL) begin
                if (parity_ok) begin
                  word_data  <= shift_data;
                  word_valid <= 1'b1;
                  word_cnt   <= word_cnt + 1'b1;
                  if (word_cnt == WORD_LAST) begin
                    state      <= ST_FORWARD;
                    fwd_enable <= 1'b1;
                  end
                end else begin
                  parity_error <= 1'b1;
                  state        <= ST_HALT;
                end
              end else begin
                if (!parity_ok) parity_error <= 1'b1;
                if (word_cnt != WORD_MAX) word_cnt <= word_cnt + 1'b1;
              end
            end
          end
        end
        default: fwd_enable <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_frame_sequencer.sv
// Self-checking bench: two sequencer instances against a bit-list reference model.
module tb_tt_um_hoene_frame_sequencer;

  localparam int DB = 24;
  localparam int P_LW [2] = '{1, 2};
  localparam int P_TO [2] = '{255, 40};

  logic clk = 1'b0;
  logic rst, in_data, in_clk, in_sync;
  logic [4:0] bc_a, bc_b;
  logic [DB-1:0] wd_a, wd_b;
  logic wv_a, wv_b, fe_a, fe_b, pe_a, pe_b, to_a, to_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: list of bits received in the current word, plus frame flags
  bit m_hist [2][32];
  int m_n [2], m_idle [2], m_acc [2], m_wd [2];
  bit m_active [2], m_halt [2], m_fwd [2], m_pe [2], m_to [2], m_valid [2];

  always #5 clk = ~clk;

  tt_um_hoene_frame_sequencer #(.DATA_BITS(DB), .LOCAL_WORDS(1), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_clk(in_clk), .in_sync(in_sync),
    .bit_counter(bc_a), .word_data(wd_a), .word_valid(wv_a), .fwd_enable(fe_a),
    .parity_error(pe_a), .timeout(to_a)
  );

  tt_um_hoene_frame_sequencer #(.DATA_BITS(DB), .LOCAL_WORDS(2), .TIMEOUT(40)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_clk(in_clk), .in_sync(in_sync),
    .bit_counter(bc_b), .word_data(wd_b), .word_valid(wv_b), .fwd_enable(fe_b),
    .parity_error(pe_b), .timeout(to_b)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_idle[k] = 0; m_acc[k] = 0; m_wd[k] = 0;
      m_active[k] = 0; m_halt[k] = 0; m_fwd[k] = 0; m_pe[k] = 0; m_to[k] = 0; m_valid[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic s, input logic c, input logic d);
    bit was;
    int x, val;
    m_valid[k] = 0;
    if (!s) begin
      m_active[k] = 0; m_halt[k] = 0; m_fwd[k] = 0; m_pe[k] = 0; m_to[k] = 0;
      m_n[k] = 0; m_idle[k] = 0; m_acc[k] = 0;
    end else if (!m_halt[k]) begin
      was = m_active[k];
      m_active[k] = 1;
      if (c) begin
        m_idle[k] = 0;
        m_hist[k][m_n[k]] = d;
        m_n[k]++;
        if (m_n[k] == DB + 1) begin
          x = 0; val = 0;
          for (int i = 0; i <= DB; i++) x ^= int'(m_hist[k][i]);
          for (int i = 0; i < DB; i++) val = val * 2 + int'(m_hist[k][i]);
          m_n[k] = 0;
          if (!m_fwd[k]) begin
            if (x == 0) begin
              m_wd[k] = val; m_valid[k] = 1; m_acc[k]++;
              if (m_acc[k] == P_LW[k]) m_fwd[k] = 1;
            end else begin
              m_pe[k] = 1; m_halt[k] = 1;
            end
          end else if (x != 0) begin
            m_pe[k] = 1;
          end
        end
      end else if (was) begin
        m_idle[k]++;
        if (m_idle[k] == P_TO[k]) begin
          m_to[k] = 1; m_halt[k] = 1; m_fwd[k] = 0;
        end
      end
    end
  endtask

  task automatic cmp_inst(input int k, input string nm, input logic [4:0] bc, input logic [DB-1:0] wd,
                          input logic wv, input logic fe, input logic pe, input logic to);
    chk_val({nm, "_bit_counter"}, 32'(bc), 32'(m_n[k]));
    chk_val({nm, "_word_data"}, 32'(wd), 32'(m_wd[k]));
    chk_val({nm, "_word_valid"}, 32'(wv), 32'(m_valid[k]));
    chk_val({nm, "_fwd_enable"}, 32'(fe), 32'(m_fwd[k]));
    chk_val({nm, "_parity_error"}, 32'(pe), 32'(m_pe[k]));
    chk_val({nm, "_timeout"}, 32'(to), 32'(m_to[k]));
  endtask

  task automatic cycle(input logic s, input logic c, input logic d);
    in_sync = s; in_clk = c; in_data = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, s, c, d);
    #1;
    cyc++;
    cmp_inst(0, "a", bc_a, wd_a, wv_a, fe_a, pe_a, to_a);
    cmp_inst(1, "b", bc_b, wd_b, wv_b, fe_b, pe_b, to_b);
  endtask

  task automatic send_word(input logic [DB-1:0] w, input logic p);
    for (int i = DB - 1; i >= 0; i--) cycle(1'b1, 1'b1, w[i]);
    cycle(1'b1, 1'b1, p);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int c1, c2, saved;
    logic [DB-1:0] w;
    logic p;
    rst = 1'b1; in_sync = 1'b0; in_clk = 1'b0; in_data = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_val("reset_a_all", {bc_a, wd_a, wv_a, fe_a, pe_a, to_a} == '0, 1);
    chk_val("reset_b_all", {bc_b, wd_b, wv_b, fe_b, pe_b, to_b} == '0, 1);
    rst = 1'b0;
    cycle(0, 0, 0);

    // async reset in the middle of a word
    w = 24'h5A5A5A;
    for (int i = DB - 1; i >= 14; i--) cycle(1, 1, w[i]);
    chk_val("pre_rst_bc", 32'(bc_a), 10);
    #2 rst = 1'b1;
    #1;
    chk_val("async_rst_a", {bc_a, wd_a, wv_a, fe_a, pe_a, to_a} == '0, 1);
    chk_val("async_rst_b", {bc_b, wd_b, wv_b, fe_b, pe_b, to_b} == '0, 1);
    model_reset();
    in_sync = 1'b0; in_clk = 1'b0;
    #3 rst = 1'b0;
    cycle(0, 0, 0);

    // good word then forwarded word with correct parity
    send_word(24'hA5F00F, 1'b0);
    chk_val("t2_valid_a", 32'(wv_a), 1);
    chk_val("t2_data_a", 32'(wd_a), 32'hA5F00F);
    chk_val("t2_fwd_a", 32'(fe_a), 1);
    chk_val("t2_fwd_b_early", 32'(fe_b), 0);
    send_word(24'h123456, 1'b1);
    chk_val("t2_fwd_word_valid_a", 32'(wv_a), 0);
    chk_val("t2_pe_a", 32'(pe_a), 0);
    chk_val("t2_bc_a", 32'(bc_a), 0);
    chk_val("t2_fwd_b", 32'(fe_b), 1);
    cycle(0, 0, 0);

    // parity failure halts
    send_word(24'hA5F00F, 1'b1);
    chk_val("t3_pe_a", 32'(pe_a), 1);
    chk_val("t3_valid_a", 32'(wv_a), 0);
    chk_val("t3_fwd_a", 32'(fe_a), 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1);
    chk_val("t3_bc_frozen", 32'(bc_a), 0);
    cycle(0, 0, 0);
    chk_val("t3_pe_clear", 32'(pe_a), 0);

    // stall timeout
    for (int i = 0; i < 10; i++) cycle(1, 1, i[0]);
    idle_cycles(254);
    chk_val("t4_to_254", 32'(to_a), 0);
    idle_cycles(1);
    chk_val("t4_to_255", 32'(to_a), 1);
    chk_val("t4_bc_frozen", 32'(bc_a), 10);
    cycle(0, 0, 0);
    chk_val("t4_to_clear", 32'(to_a), 0);
    chk_val("t4_bc_clear", 32'(bc_a), 0);

    // sync drop coincident with a bit
    for (int i = 0; i < 12; i++) cycle(1, 1, 1);
    chk_val("t5_bc12", 32'(bc_a), 12);
    saved = 32'(wd_a);
    cycle(0, 1, 1);
    chk_val("t5_bc0", 32'(bc_a), 0);
    chk_val("t5_wd_hold", 32'(wd_a), 32'(saved));
    send_word(24'h000001, 1'b1);
    chk_val("t5_wd", 32'(wd_a), 1);
    cycle(0, 0, 0);

    // back-to-back words, LOCAL_WORDS=2 instance
    send_word(24'h000003, 1'b0);
    c1 = cyc;
    chk_val("t6_valid1_b", 32'(wv_b), 1);
    chk_val("t6_fwd1_b", 32'(fe_b), 0);
    send_word(24'hFFFFFF, 1'b0);
    c2 = cyc;
    chk_val("t6_valid2_b", 32'(wv_b), 1);
    chk_val("t6_fwd2_b", 32'(fe_b), 1);
    chk_val("t6_wd_b", 32'(wd_b), 32'hFFFFFF);
    chk_val("t6_spacing", 32'(c2 - c1), 25);
    cycle(0, 0, 0);

    // randomized frames with gaps, stalls, parity errors and sync drops
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(1, 3)) cycle(0, $urandom_range(0, 1), $urandom_range(0, 1));
      for (int wi = 0; wi < int'($urandom_range(1, 4)); wi++) begin
        w = DB'($urandom);
        p = (^w) ^ ($urandom_range(0, 7) == 0);
        for (int i = DB; i >= 0; i--) begin
          if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(0, 2));
          if ($urandom_range(0, 299) == 0) idle_cycles(45);
          if ($urandom_range(0, 199) == 0) cycle(0, 1, $urandom_range(0, 1));
          cycle(1, 1, (i == 0) ? p : w[i-1]);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
